// File: rtl/rpn_stack_ctrl.sv
// RPN command sequencer driving a 16-bit LIFO stack: decodes push/pop/arith/dup/swap/clear
// commands into single-cycle stack strobes and returns one result/status word per command.
module rpn_stack_ctrl #(
   parameter int DW = 16,
   parameter int CW = 16
) (
   input  logic          iclk,
   input  logic          ireset,
   input  logic          icmd_valid,
   output logic          ocmd_ready,
   input  logic [2:0]    icmd_op,
   input  logic [DW-1:0] icmd_data,
   output logic          orsp_valid,
   input  logic          irsp_ready,
   output logic [DW-1:0] orsp_data,
   output logic [1:0]    orsp_status,
   output logic          ostk_push,
   output logic          ostk_pop,
   output logic [DW-1:0] ostk_wdata,
   input  logic [DW-1:0] istk_top,
   input  logic          istk_empty,
   input  logic          istk_full
);

   typedef enum logic [2:0] {IDLE, OPA, OPB, WB1, WB2, CLR, RESP} state_t;
   typedef enum logic [2:0] {
      OP_PUSH = 3'b000, OP_POP = 3'b001, OP_ADD = 3'b010, OP_SUB  = 3'b011,
      OP_MUL  = 3'b100, OP_DUP = 3'b101, OP_SWAP = 3'b110, OP_CLR = 3'b111
   } op_t;

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_UNDER = 2'b01;
   localparam logic [1:0] ST_OVER  = 2'b10;

   state_t        state, stateNext;
   op_t           opReg;
   logic [DW-1:0] dataReg, aReg, bReg, wbVal, cntExt;
   logic [CW-1:0] clrCnt;

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: if (icmd_valid) stateNext = (op_t'(icmd_op) == OP_CLR) ? CLR : OPA;
         OPA: begin
            unique case (opReg)
               OP_PUSH, OP_POP, OP_CLR: stateNext = RESP;
               OP_DUP:  stateNext = (istk_empty || istk_full) ? RESP : WB1;
               default: stateNext = istk_empty ? RESP : OPB;
            endcase
         end
         OPB:  stateNext = istk_empty ? RESP : WB1;
         WB1:  stateNext = (opReg == OP_SWAP) ? WB2 : RESP;
         WB2:  stateNext = RESP;
         CLR:  if (istk_empty) stateNext = RESP;
         RESP: if (irsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      unique case (opReg)
         OP_ADD:  wbVal = bReg + aReg;
         OP_SUB:  wbVal = bReg - aReg;
         OP_MUL:  wbVal = bReg * aReg;
         default: wbVal = aReg;
      endcase
   end

   always_comb begin
      cntExt = '0;
      cntExt[CW-1:0] = clrCnt;
   end

   // Strobes are decoded from the registered state and the live stack flags.
   always_comb begin
      ocmd_ready = (state == IDLE);
      orsp_valid = (state == RESP);
      ostk_push  = 1'b0;
      ostk_pop   = 1'b0;
      ostk_wdata = '0;
      unique case (state)
         OPA: begin
            unique case (opReg)
               OP_PUSH: begin
                  ostk_push  = !istk_full;
                  ostk_wdata = istk_full ? '0 : dataReg;
               end
               OP_POP, OP_ADD, OP_SUB, OP_MUL, OP_SWAP: ostk_pop = !istk_empty;
               default: ;
            endcase
         end
         OPB: begin
            if (istk_empty) begin
               ostk_push  = 1'b1;
               ostk_wdata = aReg;
            end else begin
               ostk_pop = 1'b1;
            end
         end
         WB1: begin
            ostk_push  = 1'b1;
            ostk_wdata = wbVal;
         end
         WB2: begin
            ostk_push  = 1'b1;
            ostk_wdata = bReg;
         end
         CLR: ostk_pop = !istk_empty;
         default: ;
      endcase
   end

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         opReg       <= OP_PUSH;
         dataReg     <= '0;
         aReg        <= '0;
         bReg        <= '0;
         clrCnt      <= '0;
         orsp_data   <= '0;
         orsp_status <= ST_OK;
      end else begin
         unique case (state)
            IDLE: begin
               if (icmd_valid) begin
                  opReg   <= op_t'(icmd_op);
                  dataReg <= icmd_data;
                  clrCnt  <= '0;
               end
            end
            OPA: begin
               unique case (opReg)
                  OP_PUSH: begin
                     orsp_data   <= istk_full ? '0 : dataReg;
                     orsp_status <= istk_full ? ST_OVER : ST_OK;
                  end
                  OP_POP: begin
                     aReg        <= istk_top;
                     orsp_data   <= istk_empty ? '0 : istk_top;
                     orsp_status <= istk_empty ? ST_UNDER : ST_OK;
                  end
                  OP_DUP: begin
                     aReg        <= istk_top;
                     orsp_data   <= '0;
                     orsp_status <= istk_empty ? ST_UNDER : (istk_full ? ST_OVER : ST_OK);
                  end
                  default: begin
                     aReg        <= istk_top;
                     orsp_data   <= '0;
                     orsp_status <= istk_empty ? ST_UNDER : ST_OK;
                  end
               endcase
            end
            OPB: begin
               bReg <= istk_top;
               if (istk_empty) begin
                  orsp_data   <= aReg;
                  orsp_status <= ST_UNDER;
               end
            end
            WB1: begin
               orsp_data   <= wbVal;
               orsp_status <= ST_OK;
            end
            WB2: begin
               orsp_data   <= bReg;
               orsp_status <= ST_OK;
            end
            CLR: begin
               if (!istk_empty) begin
                  if (clrCnt != '1) clrCnt <= clrCnt + CW'(1);
               end else begin
                  orsp_data   <= cntExt;
                  orsp_status <= ST_OK;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Self-checking bench for rpn_stack_ctrl: a 32-deep LIFO environment plus a queue-based
// RPN reference model that predicts response data, status, latency and strobe counts.
module tb_rpn_stack_ctrl;

   localparam int DEPTH = 32;

   logic        iclk, ireset;
   logic        icmd_valid, ocmd_ready;
   logic [2:0]  icmd_op;
   logic [15:0] icmd_data;
   logic        orsp_valid, irsp_ready;
   logic [15:0] orsp_data;
   logic [1:0]  orsp_status;
   logic        ostk_push, ostk_pop;
   logic [15:0] ostk_wdata, istk_top;
   logic        istk_empty, istk_full;

   logic [15:0] mem [DEPTH];
   int          stkCnt;
   logic [15:0] refStk [$];
   int          nVec, nErr;

   rpn_stack_ctrl #(.DW(16), .CW(16)) dut (
      .iclk(iclk), .ireset(ireset),
      .icmd_valid(icmd_valid), .ocmd_ready(ocmd_ready),
      .icmd_op(icmd_op), .icmd_data(icmd_data),
      .orsp_valid(orsp_valid), .irsp_ready(irsp_ready),
      .orsp_data(orsp_data), .orsp_status(orsp_status),
      .ostk_push(ostk_push), .ostk_pop(ostk_pop), .ostk_wdata(ostk_wdata),
      .istk_top(istk_top), .istk_empty(istk_empty), .istk_full(istk_full)
   );

   initial begin
      iclk = 0;
      forever #5 iclk = ~iclk;
   end

   // LIFO environment sharing ireset with the controller
   always @(posedge iclk or posedge ireset) begin
      if (ireset) stkCnt <= 0;
      else if (ostk_push && stkCnt < DEPTH) begin
         mem[stkCnt] <= ostk_wdata;
         stkCnt      <= stkCnt + 1;
      end else if (ostk_pop && stkCnt > 0) stkCnt <= stkCnt - 1;
   end

   assign istk_top   = (stkCnt > 0) ? mem[stkCnt-1] : 16'h0;
   assign istk_empty = (stkCnt == 0);
   assign istk_full  = (stkCnt == DEPTH);

   task automatic end_run();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [15:0] d, input int hold, input string name);
      logic [15:0] expData, a, b;
      logic [1:0]  expSt;
      int          expLat, expPush, expPop, n, cycles, nPush, nPop, coll;
      n = refStk.size();
      expData = 16'h0; expSt = 2'b00; expLat = 2; expPush = 0; expPop = 0;
      case (op)
         3'd0: if (n == DEPTH) expSt = 2'b10;
               else begin refStk.push_back(d); expData = d; expPush = 1; end
         3'd1: if (n == 0) expSt = 2'b01;
               else begin expData = refStk.pop_back(); expPop = 1; end
         3'd5: if (n == 0) expSt = 2'b01;
               else if (n == DEPTH) expSt = 2'b10;
               else begin
                  expData = refStk[n-1]; refStk.push_back(expData); expPush = 1; expLat = 3;
               end
         3'd7: begin expData = 16'(n); refStk.delete(); expPop = n; expLat = n + 2; end
         default: begin
            if (n == 0) expSt = 2'b01;
            else if (n == 1) begin
               expData = refStk[0]; expSt = 2'b01; expPop = 1; expPush = 1; expLat = 3;
            end else begin
               a = refStk.pop_back(); b = refStk.pop_back(); expPop = 2;
               if (op == 3'd6) begin
                  refStk.push_back(a); refStk.push_back(b);
                  expData = b; expPush = 2; expLat = 5;
               end else begin
                  case (op)
                     3'd2:    expData = b + a;
                     3'd3:    expData = b - a;
                     default: expData = b * a;
                  endcase
                  refStk.push_back(expData); expPush = 1; expLat = 4;
               end
            end
         end
      endcase

      icmd_valid = 1; icmd_op = op; icmd_data = d;
      nVec++;
      if (ocmd_ready !== 1'b1) begin
         nErr++; $display("FAIL %s cmd_ready: got %b, expected 1", name, ocmd_ready);
      end
      @(posedge iclk);
      @(negedge iclk);
      icmd_valid = 0; icmd_data = $urandom;
      cycles = 1; nPush = 0; nPop = 0; coll = 0;
      while (!orsp_valid && cycles < 200) begin
         if (ostk_push) nPush++;
         if (ostk_pop) nPop++;
         if (ostk_push && ostk_pop) coll++;
         @(negedge iclk);
         cycles++;
      end
      if (cycles >= 200) begin
         nVec++; nErr++;
         $display("FAIL %s timeout: no rsp_valid after %0d cycles, expected at %0d", name, cycles, expLat);
         end_run();
         return;
      end
      nVec += 6;
      if (cycles != expLat) begin nErr++; $display("FAIL %s latency: got %0d, expected %0d", name, cycles, expLat); end
      if (orsp_data !== expData) begin nErr++; $display("FAIL %s data: got %h, expected %h", name, orsp_data, expData); end
      if (orsp_status !== expSt) begin nErr++; $display("FAIL %s status: got %b, expected %b", name, orsp_status, expSt); end
      if (nPush != expPush) begin nErr++; $display("FAIL %s push count: got %0d, expected %0d", name, nPush, expPush); end
      if (nPop != expPop) begin nErr++; $display("FAIL %s pop count: got %0d, expected %0d", name, nPop, expPop); end
      if (coll != 0) begin nErr++; $display("FAIL %s push+pop same cycle: got %0d, expected 0", name, coll); end

      for (int h = 0; h < hold; h++) begin
         @(negedge iclk);
         nVec++;
         if (orsp_valid !== 1'b1 || orsp_data !== expData || ocmd_ready !== 1'b0) begin
            nErr++;
            $display("FAIL %s hold%0d: got valid=%b data=%h ready=%b, expected 1 %h 0",
                     name, h, orsp_valid, orsp_data, ocmd_ready, expData);
         end
      end
      irsp_ready = 1;
      @(posedge iclk);
      @(negedge iclk);
      irsp_ready = 0;
      nVec++;
      if (orsp_valid !== 1'b0 || ocmd_ready !== 1'b1) begin
         nErr++; $display("FAIL %s post-handshake: got valid=%b ready=%b, expected 0 1", name, orsp_valid, ocmd_ready);
      end
      nVec++;
      if (stkCnt != refStk.size()) begin
         nErr++; $display("FAIL %s stack depth: got %0d, expected %0d", name, stkCnt, refStk.size());
      end else begin
         for (int i = 0; i < stkCnt; i++)
            if (mem[i] !== refStk[i]) begin
               nErr++; $display("FAIL %s stack[%0d]: got %h, expected %h", name, i, mem[i], refStk[i]);
            end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      nVec++;
      if (ocmd_ready !== 1'b1 || orsp_valid !== 1'b0 || orsp_data !== 16'h0 || orsp_status !== 2'b00 ||
          ostk_push !== 1'b0 || ostk_pop !== 1'b0 || ostk_wdata !== 16'h0) begin
         nErr++;
         $display("FAIL %s: got ready=%b valid=%b data=%h st=%b push=%b pop=%b wdata=%h, expected 1 0 0000 00 0 0 0000",
                  name, ocmd_ready, orsp_valid, orsp_data, orsp_status, ostk_push, ostk_pop, ostk_wdata);
      end
   endtask

   task automatic test_reset();
      ireset = 1;
      repeat (2) @(negedge iclk);
      check_reset_outputs("reset");
      ireset = 0;
      @(negedge iclk);
      check_reset_outputs("post_reset_idle");
   endtask

   task automatic test_sub();
      do_cmd(3'd0, 16'd5, 0, "sub_push5");
      do_cmd(3'd0, 16'd3, 0, "sub_push3");
      do_cmd(3'd3, 16'h0, 0, "sub");
   endtask

   task automatic test_underflow();
      do_cmd(3'd1, 16'h0, 0, "pop_prev");
      do_cmd(3'd1, 16'h0, 0, "pop_empty");
      do_cmd(3'd0, 16'd7, 0, "uf_push7");
      do_cmd(3'd2, 16'h0, 0, "add_restore");
   endtask

   task automatic test_full();
      do_cmd(3'd7, 16'h0, 0, "full_pre_clr");
      for (int i = 0; i < DEPTH; i++) do_cmd(3'd0, 16'($urandom), 0, "fill_push");
      do_cmd(3'd0, 16'hBEEF, 0, "push_overflow");
      do_cmd(3'd5, 16'h0, 0, "dup_full");
      do_cmd(3'd7, 16'h0, 0, "clr_full");
   endtask

   task automatic test_wrap();
      do_cmd(3'd0, 16'hFFFF, 0, "wrap_push");
      do_cmd(3'd0, 16'h0002, 0, "wrap_push");
      do_cmd(3'd2, 16'h0, 0, "add_wrap");
      do_cmd(3'd0, 16'h0100, 0, "mul_push");
      do_cmd(3'd0, 16'h0100, 0, "mul_push");
      do_cmd(3'd4, 16'h0, 0, "mul_wrap");
   endtask

   task automatic test_swap_clr();
      do_cmd(3'd0, 16'd1, 0, "swap_push1");
      do_cmd(3'd0, 16'd2, 0, "swap_push2");
      do_cmd(3'd6, 16'h0, 0, "swap");
      do_cmd(3'd1, 16'h0, 0, "swap_pop1");
      do_cmd(3'd1, 16'h0, 0, "swap_pop2");
      do_cmd(3'd0, 16'd9, 0, "clr_fill");
      do_cmd(3'd7, 16'h0, 0, "clr3");
      nVec++;
      if (istk_empty !== 1'b1) begin nErr++; $display("FAIL clr3 empty: got %b, expected 1", istk_empty); end
      do_cmd(3'd7, 16'h0, 0, "clr_empty");
   endtask

   task automatic test_back_to_back();
      do_cmd(3'd0, 16'h1234, 5, "backpressure");
      do_cmd(3'd5, 16'h0, 2, "dup_hold");
   endtask

   task automatic test_reset_mid();
      do_cmd(3'd0, 16'h0011, 0, "mid_push");
      icmd_valid = 1; icmd_op = 3'd2; icmd_data = 16'h0;
      @(posedge iclk);
      @(negedge iclk);
      icmd_valid = 0;
      @(negedge iclk);
      nVec++;
      if (ostk_pop !== 1'b1) begin nErr++; $display("FAIL mid_opb_pop: got %b, expected 1", ostk_pop); end
      ireset = 1;
      #1;
      check_reset_outputs("reset_mid_opb");
      refStk.delete();
      @(negedge iclk);
      ireset = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge iclk);
         nVec++;
         if (orsp_valid !== 1'b0) begin nErr++; $display("FAIL mid_no_rsp: got %b, expected 0", orsp_valid); end
      end
      nVec++;
      if (stkCnt != 0) begin nErr++; $display("FAIL mid_stack_depth: got %0d, expected 0", stkCnt); end
   endtask

   task automatic test_random();
      logic [2:0] op;
      int r;
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 15);
         case (r)
            0, 1, 2, 3, 4, 5: op = 3'd0;
            6, 7:             op = 3'd1;
            8, 14:            op = 3'd2;
            9:                op = 3'd3;
            10:               op = 3'd4;
            11, 15:           op = 3'd5;
            12:               op = 3'd6;
            default:          op = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'd0;
         endcase
         do_cmd(op, 16'($urandom), $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      nVec = 0; nErr = 0;
      ireset = 1; icmd_valid = 0; icmd_op = 3'd0; icmd_data = 16'h0; irsp_ready = 0;
      @(negedge iclk);
      test_reset();
      test_sub();
      test_underflow();
      test_full();
      test_wrap();
      test_swap_clr();
      test_back_to_back();
      test_reset_mid();
      test_random();
      end_run();
   end

endmodule
